// File: rtl/nec_ir_rx.sv
// NEC IR frame decoder: synchronizes the active-low IR line, times bursts and
// spaces in microseconds, and decodes leader, 32 data bits and repeat codes.
module nec_ir_rx #(
  parameter int CLK_PER_US = 50,
  // Divides every microsecond threshold; 1 gives standard NEC timing.
  parameter int T_DIV      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ir_rxb,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_repeat,
  output logic        o_err
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  localparam logic [13:0] LL_MIN  = 14'(8000 / T_DIV);
  localparam logic [13:0] LL_MAX  = 14'(10000 / T_DIV);
  localparam logic [13:0] LH_MIN  = 14'(4000 / T_DIV);
  localparam logic [13:0] LH_MAX  = 14'(5000 / T_DIV);
  localparam logic [13:0] RH_MIN  = 14'(2000 / T_DIV);
  localparam logic [13:0] RH_MAX  = 14'(2500 / T_DIV);
  localparam logic [13:0] BIT_MIN = 14'(400 / T_DIV);
  localparam logic [13:0] BIT_MAX = 14'(720 / T_DIV);
  localparam logic [13:0] ONE_THR = 14'(1400 / T_DIV);
  localparam logic [13:0] GAP_MAX = 14'(1900 / T_DIV);
  localparam logic [13:0] DUR_SAT = 14'h3fff;

  // Repeat burst and post-frame stop burst behave identically, so they share STOP_LOW.
  typedef enum logic [2:0] {
    IDLE, LEAD_LOW, LEAD_HIGH, DATA_LOW, DATA_HIGH, WAIT_FALL, STOP_LOW, WAIT_HIGH
  } state_t;

  state_t        state, nstate;
  logic          sync1, sync2, prev;
  logic          fall, rise, chg;
  logic [PW-1:0] psc;
  logic          us_tick;
  logic [13:0]   dur;
  logic [4:0]    bitcnt;
  logic [31:0]   shreg;
  logic          bit0, bit1, resolve, last, frame_done;
  logic          err_d, rep_d, valid_d, shift, clr_cnt;

  function automatic logic in_rng(input logic [13:0] d, input logic [13:0] lo,
                                  input logic [13:0] hi);
    return (d >= lo) && (d <= hi);
  endfunction

  // Two-flop synchronizer plus previous-sample flop, all idling high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= i_ir_rxb;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign fall    = prev & ~sync2;
  assign rise    = ~prev & sync2;
  assign chg     = fall | rise;
  assign us_tick = (psc == PW'(CLK_PER_US - 1));

  // Microsecond prescaler and saturating duration counter, restarted on every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
      dur <= '0;
    end else if (chg) begin
      psc <= '0;
      dur <= '0;
    end else begin
      psc <= us_tick ? '0 : psc + PW'(1);
      if (us_tick && dur != DUR_SAT) dur <= dur + 14'd1;
    end
  end

  // A zero is resolved by the closing fall, a one by the space reaching the threshold.
  assign bit0    = (state == DATA_HIGH) && fall && in_rng(dur, BIT_MIN, BIT_MAX);
  assign bit1    = (state == DATA_HIGH) && !fall && (dur >= ONE_THR);
  assign resolve = bit0 | bit1;
  assign last    = (bitcnt == 5'd31);
  // The bit counter wraps to 0 after bit 31, so WAIT_FALL with a zero count is post-frame.
  assign frame_done = (bitcnt == 5'd0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // Next-state decode from edges and measured duration.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:      if (fall) nstate = LEAD_LOW;
      LEAD_LOW:  if (rise) nstate = in_rng(dur, LL_MIN, LL_MAX) ? LEAD_HIGH : IDLE;
                 else if (dur > LL_MAX) nstate = WAIT_HIGH;
      LEAD_HIGH: if (fall) begin
                   if (in_rng(dur, LH_MIN, LH_MAX))      nstate = DATA_LOW;
                   else if (in_rng(dur, RH_MIN, RH_MAX)) nstate = STOP_LOW;
                   else                                  nstate = IDLE;
                 end else if (dur > LH_MAX) nstate = IDLE;
      DATA_LOW:  if (rise) nstate = in_rng(dur, BIT_MIN, BIT_MAX) ? DATA_HIGH : WAIT_HIGH;
                 else if (dur > BIT_MAX) nstate = WAIT_HIGH;
      DATA_HIGH: if (bit1)      nstate = WAIT_FALL;
                 else if (bit0) nstate = last ? STOP_LOW : DATA_LOW;
                 else if (fall) nstate = IDLE;
      WAIT_FALL: if (fall) nstate = frame_done ? STOP_LOW : DATA_LOW;
                 else if (dur > GAP_MAX) nstate = IDLE;
      STOP_LOW:  if (rise) nstate = IDLE;
                 else if (dur > BIT_MAX) nstate = WAIT_HIGH;
      WAIT_HIGH: if (rise) nstate = IDLE;
      default:   nstate = IDLE;
    endcase
  end

  // Pulse requests and datapath controls for the decision being taken this cycle.
  always_comb begin
    err_d   = 1'b0;
    rep_d   = 1'b0;
    valid_d = 1'b0;
    shift   = 1'b0;
    clr_cnt = 1'b0;
    case (state)
      LEAD_LOW:  err_d = rise ? !in_rng(dur, LL_MIN, LL_MAX) : (dur > LL_MAX);
      LEAD_HIGH: if (fall) begin
                   clr_cnt = in_rng(dur, LH_MIN, LH_MAX);
                   rep_d   = in_rng(dur, RH_MIN, RH_MAX);
                   err_d   = !clr_cnt && !rep_d;
                 end else begin
                   err_d = (dur > LH_MAX);
                 end
      DATA_LOW:  err_d = rise ? !in_rng(dur, BIT_MIN, BIT_MAX) : (dur > BIT_MAX);
      DATA_HIGH: begin
                   shift   = resolve;
                   valid_d = resolve && last;
                   err_d   = fall && !resolve;
                 end
      WAIT_FALL: err_d = !frame_done && !fall && (dur > GAP_MAX);
      default:   ;
    endcase
  end

  // Shift register, bit counter and registered outputs; o_data only loads complete frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt   <= '0;
      shreg    <= '0;
      o_data   <= '0;
      o_valid  <= 1'b0;
      o_repeat <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_valid  <= valid_d;
      o_repeat <= rep_d;
      o_err    <= err_d;
      if (clr_cnt) begin
        bitcnt <= '0;
      end else if (shift) begin
        bitcnt <= bitcnt + 5'd1;
        shreg  <= {bit1, shreg[31:1]};
      end
      if (valid_d) o_data <= {bit1, shreg[31:1]};
    end
  end

endmodule
